// File: rtl/eth_arp_payload_tx.sv
// ARP reply payload serializer: 28-byte body plus optional zero pad, one byte per aclk after the start pulse.
// Latency: first byte one cycle after start; no backpressure, starts while busy are dropped.
module eth_arp_payload_tx #(
  parameter logic [15:0] OPER_CODE = 16'h0002,
  parameter int          PAD_EN    = 1,
  parameter int          PAD_LEN   = 18
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        eth_header_arp_valid_done,
  input  logic [47:0] mac_s_addr,
  input  logic [31:0] ip_s_addr,
  input  logic [47:0] mac_d_addr,
  input  logic [31:0] ip_d_addr,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        arp_payload_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FIXED, S_SHA, S_SPA, S_THA, S_TPA, S_PAD
  } state_t;

  localparam logic [63:0] C_FIXED  = {16'h0001, 16'h0800, 8'h06, 8'h04, OPER_CODE};
  localparam bit          HAS_PAD  = (PAD_EN != 0) && (PAD_LEN > 0);
  localparam logic [5:0]  PAD_LAST = (PAD_LEN > 0) ? 6'(PAD_LEN - 1) : 6'd0;

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_cnt, w_cnt_nxt;
  logic [63:0] r_fixed;
  logic [47:0] r_sha, r_tha;
  logic [31:0] r_spa, r_tpa;
  logic        w_start;
  logic [7:0]  w_byte;
  logic        w_last;

  assign w_start = eth_header_arp_valid_done && (r_state == S_IDLE);

  // State, counter, field shift registers and registered outputs
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state          <= S_IDLE;
      r_cnt            <= 6'd0;
      r_fixed          <= 64'd0;
      r_sha            <= 48'd0;
      r_spa            <= 32'd0;
      r_tha            <= 48'd0;
      r_tpa            <= 32'd0;
      data_out         <= 8'h00;
      data_valid       <= 1'b0;
      busy             <= 1'b0;
      arp_payload_done <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_cnt            <= w_cnt_nxt;
      data_out         <= w_byte;
      data_valid       <= (w_state_nxt != S_IDLE);
      busy             <= (w_state_nxt != S_IDLE);
      arp_payload_done <= w_last;
      if (w_start) begin
        // Byte 0 goes out this edge straight from the constant, so load it pre-shifted
        r_fixed <= {C_FIXED[55:0], 8'h00};
        r_sha   <= mac_s_addr;
        r_spa   <= ip_s_addr;
        r_tha   <= mac_d_addr;
        r_tpa   <= ip_d_addr;
      end else begin
        if (w_state_nxt == S_FIXED) r_fixed <= r_fixed << 8;
        if (w_state_nxt == S_SHA)   r_sha   <= r_sha << 8;
        if (w_state_nxt == S_SPA)   r_spa   <= r_spa << 8;
        if (w_state_nxt == S_THA)   r_tha   <= r_tha << 8;
        if (w_state_nxt == S_TPA)   r_tpa   <= r_tpa << 8;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 6'd1;
    case (r_state)
      S_IDLE:  if (w_start)            w_state_nxt = S_FIXED;
      S_FIXED: if (r_cnt == 6'd7)      w_state_nxt = S_SHA;
      S_SHA:   if (r_cnt == 6'd5)      w_state_nxt = S_SPA;
      S_SPA:   if (r_cnt == 6'd3)      w_state_nxt = S_THA;
      S_THA:   if (r_cnt == 6'd5)      w_state_nxt = S_TPA;
      S_TPA:   if (r_cnt == 6'd3)      w_state_nxt = HAS_PAD ? S_PAD : S_IDLE;
      S_PAD:   if (r_cnt == PAD_LAST)  w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
    if ((w_state_nxt != r_state) || (r_state == S_IDLE))
      w_cnt_nxt = 6'd0;
  end

  // Byte and done flag are computed for the state being entered, then registered
  always_comb begin
    w_byte = 8'h00;
    case (w_state_nxt)
      S_FIXED: w_byte = (r_state == S_IDLE) ? C_FIXED[63:56] : r_fixed[63:56];
      S_SHA:   w_byte = r_sha[47:40];
      S_SPA:   w_byte = r_spa[31:24];
      S_THA:   w_byte = r_tha[47:40];
      S_TPA:   w_byte = r_tpa[31:24];
      default: w_byte = 8'h00;
    endcase
    w_last = ((w_state_nxt == S_TPA) && (w_cnt_nxt == 6'd3) && !HAS_PAD) ||
             ((w_state_nxt == S_PAD) && (w_cnt_nxt == PAD_LAST));
  end

endmodule

// File: tb/tb_eth_arp_payload_tx.sv
// Directed bench for eth_arp_payload_tx: padded and unpadded frames, input isolation, mid-frame reset, back-to-back spacing.
module tb_eth_arp_payload_tx;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start0, start1;
  logic [47:0] mac_s, mac_d;
  logic [31:0] ip_s, ip_d;
  logic [7:0]  d0_out, d1_out;
  logic        d0_vld, d0_busy, d0_done;
  logic        d1_vld, d1_busy, d1_done;

  int checks   = 0;
  int failures = 0;

  // Hand-written expected ARP body for the scenario-1 addresses
  logic [223:0] body = 224'h0001080006040002020000000001C0A8010AAABBCCDDEEFFC0A80164;

  always #5 aclk = ~aclk;

  eth_arp_payload_tx #(.OPER_CODE(16'h0002), .PAD_EN(1), .PAD_LEN(18)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .eth_header_arp_valid_done(start0),
    .mac_s_addr(mac_s), .ip_s_addr(ip_s), .mac_d_addr(mac_d), .ip_d_addr(ip_d),
    .data_out(d0_out), .data_valid(d0_vld), .busy(d0_busy), .arp_payload_done(d0_done));

  eth_arp_payload_tx #(.OPER_CODE(16'h0002), .PAD_EN(0), .PAD_LEN(18)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .eth_header_arp_valid_done(start1),
    .mac_s_addr(mac_s), .ip_s_addr(ip_s), .mac_d_addr(mac_d), .ip_d_addr(ip_d),
    .data_out(d1_out), .data_valid(d1_vld), .busy(d1_busy), .arp_payload_done(d1_done));

  function automatic logic [7:0] exp_byte(input int i);
    if (i < 28) return body[223 - 8*i -: 8];
    return 8'h00;
  endfunction

  task automatic set_addrs();
    mac_s = 48'h020000000001;
    ip_s  = 32'hC0A8010A;
    mac_d = 48'hAABBCCDDEEFF;
    ip_d  = 32'hC0A80164;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; start0 = 1'b0; start1 = 1'b0;
    set_addrs();
    idle(3);
    @(negedge aclk);
    checks++;
    if ({d0_out, d0_vld, d0_busy, d0_done} !== 11'h000) begin
      failures++;
      $display("FAIL reset_dut0 got=%h exp=000", {d0_out, d0_vld, d0_busy, d0_done});
    end
    checks++;
    if ({d1_out, d1_vld, d1_busy, d1_done} !== 11'h000) begin
      failures++;
      $display("FAIL reset_dut1 got=%h exp=000", {d1_out, d1_vld, d1_busy, d1_done});
    end
    aresetn = 1'b1;
    idle(2);
  endtask

  task automatic test_basic_pad();
    logic [10:0] exp_v;
    @(posedge aclk); #1; start0 = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      @(posedge aclk); #1; start0 = 1'b0;
      @(negedge aclk);
      exp_v = (k <= 46) ? {exp_byte(k-1), 1'b1, 1'b1, (k == 46)} : 11'h000;
      checks++;
      if ({d0_out, d0_vld, d0_busy, d0_done} !== exp_v) begin
        failures++;
        $display("FAIL basic_pad cycle=%0d got=%h exp=%h", k, {d0_out, d0_vld, d0_busy, d0_done}, exp_v);
      end
    end
    idle(3);
  endtask

  task automatic test_nopad();
    logic [10:0] exp_v;
    @(posedge aclk); #1; start1 = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      @(posedge aclk); #1; start1 = 1'b0;
      @(negedge aclk);
      exp_v = (k <= 28) ? {exp_byte(k-1), 1'b1, 1'b1, (k == 28)} : 11'h000;
      checks++;
      if ({d1_out, d1_vld, d1_busy, d1_done} !== exp_v) begin
        failures++;
        $display("FAIL nopad cycle=%0d got=%h exp=%h", k, {d1_out, d1_vld, d1_busy, d1_done}, exp_v);
      end
    end
    idle(3);
  endtask

  task automatic test_input_isolation();
    logic [10:0] exp_v;
    int done_cnt = 0;
    @(posedge aclk); #1; start0 = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge aclk); #1; start0 = 1'b0;
      if (k == 3) begin
        mac_s = 48'h111111111111; ip_s = 32'h22222222;
        mac_d = 48'h333333333333; ip_d = 32'h44444444;
      end
      if (k == 10) start0 = 1'b1;
      @(negedge aclk);
      if (d0_done) done_cnt++;
      exp_v = (k <= 46) ? {exp_byte(k-1), 1'b1, 1'b1, (k == 46)} : 11'h000;
      checks++;
      if ({d0_out, d0_vld, d0_busy, d0_done} !== exp_v) begin
        failures++;
        $display("FAIL isolation cycle=%0d got=%h exp=%h", k, {d0_out, d0_vld, d0_busy, d0_done}, exp_v);
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL isolation_done_count got=%0d exp=1", done_cnt);
    end
    set_addrs();
    idle(3);
  endtask

  task automatic test_reset_midframe();
    logic [10:0] exp_v;
    @(posedge aclk); #1; start0 = 1'b1;
    for (int k = 1; k <= 68; k++) begin
      @(posedge aclk); #1; start0 = 1'b0;
      if (k == 15) aresetn = 1'b0;
      if (k == 16) aresetn = 1'b1;
      if (k == 20) start0 = 1'b1;
      @(negedge aclk);
      if (k <= 15)
        exp_v = {exp_byte(k-1), 1'b1, 1'b1, 1'b0};
      else if (k >= 21 && k <= 66)
        exp_v = {exp_byte(k-21), 1'b1, 1'b1, (k == 66)};
      else
        exp_v = 11'h000;
      checks++;
      if ({d0_out, d0_vld, d0_busy, d0_done} !== exp_v) begin
        failures++;
        $display("FAIL reset_midframe cycle=%0d got=%h exp=%h", k, {d0_out, d0_vld, d0_busy, d0_done}, exp_v);
      end
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp_v;
    @(posedge aclk); #1; start0 = 1'b1;
    for (int k = 1; k <= 95; k++) begin
      @(posedge aclk); #1; start0 = 1'b0;
      if (k == 46 || k == 47) start0 = 1'b1;
      @(negedge aclk);
      if (k <= 46)
        exp_v = {exp_byte(k-1), 1'b1, 1'b1, (k == 46)};
      else if (k >= 48 && k <= 93)
        exp_v = {exp_byte(k-48), 1'b1, 1'b1, (k == 93)};
      else
        exp_v = 11'h000;
      checks++;
      if ({d0_out, d0_vld, d0_busy, d0_done} !== exp_v) begin
        failures++;
        $display("FAIL back_to_back cycle=%0d got=%h exp=%h", k, {d0_out, d0_vld, d0_busy, d0_done}, exp_v);
      end
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_basic_pad();
    test_nopad();
    test_input_isolation();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
